conv_sequencer_param: RTL

- Parametrised successor to the fixed-count convolution controller.
- Sequences one convolution window per output: tap fetch from the input RAM and filter ROM, multiply phase, then a configurable-depth adder tree, then a store handshake.
- Repeats for NUM_OUTPUTS windows, advancing the window base by STRIDE.
- Sits between the external start/busy interface and the MAC datapath plus the memories.

---
 rtl/conv_sequencer_param.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/conv_sequencer_param.sv
// Convolution window sequencer: tap fetch, multiply, adder tree, store, repeated per output window.
// Optional macro CONV_MULT_HANDSHAKE_EN: MULT ends on an external mult_done instead of a fixed count.
module conv_sequencer_param #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned FILT_ADDR_W = 4,
  parameter int unsigned KERNEL_TAPS = 9,
  parameter int unsigned MULT_CYCLES = 16,
  parameter int unsigned ADD_LEVELS  = 4,
  parameter int unsigned ADD_CYCLES  = 8,
  parameter int unsigned NUM_OUTPUTS = 4,
  parameter int unsigned STRIDE      = 1,
  localparam int unsigned OUT_W      = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   store_ready,
`ifdef CONV_MULT_HANDSHAKE_EN
  input  logic                   mult_done,
`endif
  output logic                   busy,
  output logic                   done,
  output logic                   in_ram_en,
  output logic                   in_ram_rd_en,
  output logic [ADDR_W-1:0]      in_ram_addr,
  output logic                   filt_rom_en,
  output logic                   filt_rom_rd_en,
  output logic [FILT_ADDR_W-1:0] filt_rom_addr,
  output logic                   mult_en,
  output logic [ADD_LEVELS-1:0]  add_level_en,
  output logic                   store_valid,
  output logic [OUT_W-1:0]       out_index
);

  localparam int unsigned TAP_W  = (KERNEL_TAPS > 1) ? $clog2(KERNEL_TAPS) : 1;
  localparam int unsigned LVL_W  = (ADD_LEVELS > 1) ? $clog2(ADD_LEVELS) : 1;
  localparam int unsigned PH_MAX = (MULT_CYCLES > ADD_CYCLES) ? MULT_CYCLES : ADD_CYCLES;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_MULT  = 3'd2;
  localparam logic [2:0] S_ADD   = 3'd3;
  localparam logic [2:0] S_STORE = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  logic [2:0]        r_state,     w_state_nxt;
  logic [TAP_W-1:0]  r_tap_cnt,   w_tap_nxt;
  logic [PH_W-1:0]   r_phase_cnt, w_phase_nxt;
  logic [LVL_W-1:0]  r_level_cnt, w_level_nxt;
  logic [ADDR_W-1:0] r_win_base,  w_base_nxt;
  logic [OUT_W-1:0]  r_out_index, w_out_nxt;

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_tap_cnt   <= '0;
      r_phase_cnt <= '0;
      r_level_cnt <= '0;
      r_win_base  <= '0;
      r_out_index <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_tap_cnt   <= w_tap_nxt;
      r_phase_cnt <= w_phase_nxt;
      r_level_cnt <= w_level_nxt;
      r_win_base  <= w_base_nxt;
      r_out_index <= w_out_nxt;
    end
  end

  // Next-state and counter update; abort overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    w_tap_nxt   = r_tap_cnt;
    w_phase_nxt = r_phase_cnt;
    w_level_nxt = r_level_cnt;
    w_base_nxt  = r_win_base;
    w_out_nxt   = r_out_index;
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_tap_nxt   = '0;
      w_phase_nxt = '0;
      w_level_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt = S_LOAD;
            w_tap_nxt   = '0;
            w_phase_nxt = '0;
            w_level_nxt = '0;
            w_base_nxt  = '0;
            w_out_nxt   = '0;
          end
        end
        S_LOAD: begin
          if (r_tap_cnt == TAP_W'(KERNEL_TAPS - 1)) begin
            w_state_nxt = S_MULT;
            w_tap_nxt   = '0;
            w_phase_nxt = '0;
          end else begin
            w_tap_nxt = r_tap_cnt + TAP_W'(1);
          end
        end
        S_MULT: begin
`ifdef CONV_MULT_HANDSHAKE_EN
          if (mult_done) begin
            w_state_nxt = S_ADD;
            w_phase_nxt = '0;
            w_level_nxt = '0;
          end
`else
          if (r_phase_cnt == PH_W'(MULT_CYCLES - 1)) begin
            w_state_nxt = S_ADD;
            w_phase_nxt = '0;
            w_level_nxt = '0;
          end else begin
            w_phase_nxt = r_phase_cnt + PH_W'(1);
          end
`endif
        end
        S_ADD: begin
          if (r_phase_cnt == PH_W'(ADD_CYCLES - 1)) begin
            w_phase_nxt = '0;
            if (r_level_cnt == LVL_W'(ADD_LEVELS - 1)) begin
              w_state_nxt = S_STORE;
              w_level_nxt = '0;
            end else begin
              w_level_nxt = r_level_cnt + LVL_W'(1);
            end
          end else begin
            w_phase_nxt = r_phase_cnt + PH_W'(1);
          end
        end
        S_STORE: begin
          if (store_ready) begin
            if (r_out_index == OUT_W'(NUM_OUTPUTS - 1)) begin
              w_state_nxt = S_FIN;
            end else begin
              w_state_nxt = S_LOAD;
              w_tap_nxt   = '0;
              w_out_nxt   = r_out_index + OUT_W'(1);
              w_base_nxt  = r_win_base + ADDR_W'(STRIDE);
            end
          end
        end
        S_FIN:   w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Moore output decode of registered state and counters
  always_comb begin
    busy           = (r_state != S_IDLE);
    done           = (r_state == S_FIN);
    in_ram_en      = (r_state == S_LOAD);
    in_ram_rd_en   = (r_state == S_LOAD);
    filt_rom_en    = (r_state == S_LOAD);
    filt_rom_rd_en = (r_state == S_LOAD);
    in_ram_addr    = '0;
    filt_rom_addr  = '0;
    if (r_state == S_LOAD) begin
      in_ram_addr   = r_win_base + ADDR_W'(r_tap_cnt);
      filt_rom_addr = FILT_ADDR_W'(r_tap_cnt);
    end
    mult_en      = (r_state == S_MULT);
    add_level_en = '0;
    for (int k = 0; k < ADD_LEVELS; k++) begin
      add_level_en[k] = (r_state == S_ADD) && (r_level_cnt == LVL_W'(k));
    end
    store_valid = (r_state == S_STORE);
    out_index   = r_out_index;
  end

endmodule
